uart_rx_line_monitor: RTL
=========================

# uart_rx_line_monitor

Serial-line UART receiver for the simulation/top-level harness. It samples the chip's UART TX pin (8N1 or 8-bit with parity, LSB first) and reconstructs bytes into a small FIFO. This gives the harness a pin-accurate console path that does not depend on hierarchical taps into the UART core. It is the receiving end of the UART TX protocol and is kept synthesizable so it can also serve as an FPGA loopback checker.

## Interface
- `FifoDepth`, default 4: output FIFO entries; power of two, ≥2.
- `CntW`, default 16: width of the bit-period counter.

- `clk_i` in 1: single clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `enable_i` in 1: receiver enable; low forces IDLE. FIFO contents are kept.
- `clks_per_bit_i` in CntW: clock cycles per bit (N). Values below 4 are treated as 4. Sampled only in IDLE.
- `parity_en_i` in 1: a parity bit follows the data bits.
- `parity_odd_i` in 1: 1 = odd parity, 0 = even.
- `rx_i` in 1: asynchronous serial line, idles high.
- `rdata_o` out 8: FIFO head byte.
- `rvalid_o` out 1: FIFO non-empty.
- `rready_i` in 1: pop; a transfer happens when `rvalid_o & rready_i`.
- `frame_err_o` out 1: one-cycle pulse when a stop bit is sampled low.
- `parity_err_o` out 1: one-cycle pulse on parity mismatch.
- `overflow_o` out 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `busy_o` out 1: state ≠ IDLE.
- `fifo_depth_o` out $clog2(FifoDepth)+1: current occupancy.

## Operation
- `rx_i` passes through a 2-flop synchronizer (reset value 1). All decisions use the synchronized value `rx_s`.
- Bit-period counter: loaded and decremented each cycle; an "expiry" occurs when it reaches 0.
- States and transitions:
  - IDLE: `rx_s`==0 with `enable_i` high → START, counter = N/2−1 (integer division).
  - START: on expiry, sample `rx_s`. If 1 → glitch, go to IDLE with no error. If 0 → DATA, bit index = 0, counter = N−1.
  - DATA: on each expiry, shift `rx_s` into bit[index] (LSB first) and reload counter = N−1. After bit 7 → PARITY if `parity_en_i`, else STOP.
  - PARITY: on expiry, compare `rx_s` with the expected parity. Expected = XOR(data) for even, ~XOR(data) for odd. Latch the mismatch flag. → STOP, counter = N−1.
  - STOP: on expiry, sample `rx_s`:
    - `rx_s`==0 → `frame_err_o` pulse, byte discarded → WAIT_HIGH.
    - `rx_s`==1 with parity mismatch → `parity_err_o` pulse, byte discarded → IDLE.
    - `rx_s`==1 otherwise → push the byte → IDLE.
  - WAIT_HIGH: stay until `rx_s`==1, then → IDLE. This handles break conditions without re-triggering.
- Frame error takes precedence over parity error; only one error pulse is issued per frame.
- Push when full: if a pop happens in the same cycle, the push is accepted. Otherwise the byte is dropped and `overflow_o` pulses.
- Pop when empty: ignored.
- `enable_i` deasserted in any state → IDLE on the next edge, with counter and bit index cleared and no error pulses. A frame in progress is abandoned.
- `clks_per_bit_i` changes mid-frame have no effect until the next IDLE.

## Timing
- Reset values:
  - `rdata_o`=0, `rvalid_o`=0, `busy_o`=0, `fifo_depth_o`=0.
  - All error pulses 0.
  - Synchronizer = 1, state = IDLE.
- Start-bit sample point: N/2 cycles after start detection. Data, parity and stop bits are sampled at N-cycle spacing after that.
- End-to-end latency for 8N1: `rvalid_o` rises exactly 2 + N/2 + 9N + 1 cycles after the first rising edge at which `rx_i` is low.
- With parity enabled, the latency is N cycles longer.
- Push → `rvalid_o` is 1 cycle. Error pulses are asserted in the cycle after the stop-bit (or parity) expiry, aligned with where the push would have occurred.
- Pop → head advances on the next edge. Throughput is 1 byte/cycle at the output.
- `busy_o` falls in the same cycle that `rvalid_o` rises for a good frame.
- Reset asserted mid-frame: all outputs take their reset values immediately (asynchronously). No partial byte is ever pushed.

## Test plan
- N=16, 8N1, send 0x55 then 0xA3 back-to-back with `rready_i`=1.
  - `rdata_o`=0x55 with `rvalid_o` at cycle 155 after the first start edge, then 0xA3 exactly 160 cycles later.
  - No error pulses.
- N=16, `parity_en_i`=1, `parity_odd_i`=0:
  - Send 0x07 with parity bit 1 → byte accepted.
  - Send 0x07 with parity bit 0 → one `parity_err_o` pulse, FIFO unchanged.
- Stop bit driven low for 0x41, line held low for 40N cycles, then released, then 0x42 sent:
  - One `frame_err_o` pulse.
  - `busy_o` stays high until the line is high again.
  - Only 0x42 is received.
- 0.25N low glitch on an idle line (N=16): returns to IDLE, no push, no error.
- `rready_i`=0, send 5 bytes with FifoDepth=4:
  - `fifo_depth_o` reaches 4 and `overflow_o` pulses once.
  - The first 4 bytes pop in order.
  - Repeat with a pop coinciding with the 5th push → no overflow.
- Mid-frame disturbances:
  - Assert `rst_i` at data bit 3 → outputs return to reset values; the next clean frame is received correctly.
  - Deassert `enable_i` at data bit 5 → no push, `busy_o`=0 next cycle.

Source files
------------

// File: rtl/uart_rx_line_monitor.sv
// uart_rx_line_monitor
// Pin-level UART receiver: samples a serial line (8 data bits, LSB first,
// optional parity, one stop bit), reconstructs bytes and queues them in a
// small output FIFO. Framing, parity and overflow problems are reported as
// single-cycle pulses. Synthesizable so it can double as a loopback checker.

module uart_rx_line_monitor #(
    parameter int FifoDepth = 4,
    parameter int CntW      = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic [CntW-1:0]              clks_per_bit_i,
    input  logic                         parity_en_i,
    input  logic                         parity_odd_i,
    input  logic                         rx_i,
    output logic [7:0]                   rdata_o,
    output logic                         rvalid_o,
    input  logic                         rready_i,
    output logic                         frame_err_o,
    output logic                         parity_err_o,
    output logic                         overflow_o,
    output logic                         busy_o,
    output logic [$clog2(FifoDepth):0]   fifo_depth_o
);

    localparam int AddrW  = $clog2(FifoDepth);
    localparam int DepthW = AddrW + 1;
    localparam logic [CntW-1:0]   MinClks   = CntW'(4);
    localparam logic [CntW-1:0]   CntOne    = CntW'(1);
    localparam logic [CntW-1:0]   CntZero   = CntW'(0);
    localparam logic [DepthW-1:0] FullCount = DepthW'(FifoDepth);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_e;

    // Expected parity bit: even parity makes the total count of ones even,
    // odd parity makes it odd.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        calc_parity = (^data) ^ odd;
    endfunction

    // ------------------------------------------------------------------
    // Line synchronizer
    // ------------------------------------------------------------------
    logic rx_meta_r;
    logic rx_sync_r;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_i;
            rx_sync_r <= rx_meta_r;
        end
    end

    // ------------------------------------------------------------------
    // Receive state machine
    // ------------------------------------------------------------------
    state_e          state_r, state_s;
    logic [CntW-1:0] cnt_r, cnt_s;
    logic [CntW-1:0] nper_r, nper_s;
    logic [2:0]      idx_r, idx_s;
    logic [7:0]      shift_r, shift_s;
    logic            perr_r, perr_s;
    logic            push_r, push_s;
    logic            frame_err_r, frame_err_s;
    logic            parity_err_r, parity_err_s;
    logic            busy_r, busy_s;
    logic [CntW-1:0] clks_eff_s;
    logic            expiry_s;

    // Bit period clamped to the minimum of 4 clocks.
    always_comb begin
        if (clks_per_bit_i < MinClks) begin
            clks_eff_s = MinClks;
        end else begin
            clks_eff_s = clks_per_bit_i;
        end
    end

    assign expiry_s = (cnt_r == CntZero);

    // Next-state, counter, shift register and error/push decisions.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        nper_s       = nper_r;
        idx_s        = idx_r;
        shift_s      = shift_r;
        perr_s       = perr_r;
        push_s       = 1'b0;
        frame_err_s  = 1'b0;
        parity_err_s = 1'b0;

        if (!enable_i) begin
            // Abandon any frame in progress without reporting anything.
            state_s = ST_IDLE;
            cnt_s   = CntZero;
            idx_s   = 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Bit period is captured here and held for the whole frame.
                    nper_s = clks_eff_s;
                    if (!rx_sync_r) begin
                        state_s = ST_START;
                        cnt_s   = (clks_eff_s >> 1) - CntOne;
                        idx_s   = 3'd0;
                        perr_s  = 1'b0;
                    end else begin
                        cnt_s = CntZero;
                    end
                end
                ST_START: begin
                    if (expiry_s) begin
                        if (rx_sync_r) begin
                            // Line went back high before mid start bit: glitch.
                            state_s = ST_IDLE;
                            cnt_s   = CntZero;
                        end else begin
                            state_s = ST_DATA;
                            idx_s   = 3'd0;
                            cnt_s   = nper_r - CntOne;
                        end
                    end else begin
                        cnt_s = cnt_r - CntOne;
                    end
                end
                ST_DATA: begin
                    if (expiry_s) begin
                        // LSB arrives first, so shift in from the top.
                        shift_s = {rx_sync_r, shift_r[7:1]};
                        cnt_s   = nper_r - CntOne;
                        if (idx_r == 3'd7) begin
                            idx_s = 3'd0;
                            if (parity_en_i) begin
                                state_s = ST_PARITY;
                            end else begin
                                state_s = ST_STOP;
                            end
                        end else begin
                            idx_s = idx_r + 3'd1;
                        end
                    end else begin
                        cnt_s = cnt_r - CntOne;
                    end
                end
                ST_PARITY: begin
                    if (expiry_s) begin
                        perr_s  = (rx_sync_r != calc_parity(shift_r, parity_odd_i));
                        state_s = ST_STOP;
                        cnt_s   = nper_r - CntOne;
                    end else begin
                        cnt_s = cnt_r - CntOne;
                    end
                end
                ST_STOP: begin
                    if (expiry_s) begin
                        cnt_s = CntZero;
                        if (!rx_sync_r) begin
                            // Framing error wins over parity; wait out a break.
                            frame_err_s = 1'b1;
                            state_s     = ST_WAIT_HIGH;
                        end else if (perr_r) begin
                            parity_err_s = 1'b1;
                            state_s      = ST_IDLE;
                        end else begin
                            push_s  = 1'b1;
                            state_s = ST_IDLE;
                        end
                    end else begin
                        cnt_s = cnt_r - CntOne;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_sync_r) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_WAIT_HIGH;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = CntZero;
                    idx_s   = 3'd0;
                end
            endcase
        end

        // Busy covers the push/error cycle so it drops together with rvalid.
        busy_s = (state_s != ST_IDLE) | push_s | frame_err_s | parity_err_s;
    end

    // Receive state, counters and registered status pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CntZero;
            nper_r       <= MinClks;
            idx_r        <= 3'd0;
            shift_r      <= 8'd0;
            perr_r       <= 1'b0;
            push_r       <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            nper_r       <= nper_s;
            idx_r        <= idx_s;
            shift_r      <= shift_s;
            perr_r       <= perr_s;
            push_r       <= push_s;
            frame_err_r  <= frame_err_s;
            parity_err_r <= parity_err_s;
            busy_r       <= busy_s;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [7:0]        mem_r [FifoDepth];
    logic [AddrW-1:0]  wr_ptr_r;
    logic [AddrW-1:0]  rd_ptr_r;
    logic [DepthW-1:0] count_r;
    logic [DepthW-1:0] count_s;
    logic              rvalid_r;
    logic              overflow_r;
    logic              pop_s;
    logic              full_s;
    logic              push_ok_s;
    logic              drop_s;

    // Push/pop arbitration: a pop in the same cycle frees room for a push.
    always_comb begin
        pop_s     = rvalid_r & rready_i;
        full_s    = (count_r == FullCount);
        push_ok_s = push_r & (~full_s | pop_s);
        drop_s    = push_r & full_s & ~pop_s;
        count_s   = count_r + {{(DepthW-1){1'b0}}, push_ok_s}
                            - {{(DepthW-1){1'b0}}, pop_s};
    end

    // FIFO storage, pointers, occupancy and overflow pulse. shift_r is stable
    // during the push cycle because it only changes in the DATA state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FifoDepth; i++) begin
                mem_r[i] <= 8'd0;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            rvalid_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= shift_r;
                wr_ptr_r        <= wr_ptr_r + {{(AddrW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AddrW-1){1'b0}}, 1'b1};
            end
            count_r    <= count_s;
            rvalid_r   <= (count_s != '0);
            overflow_r <= drop_s;
        end
    end

    assign rdata_o      = mem_r[rd_ptr_r];
    assign rvalid_o     = rvalid_r;
    assign fifo_depth_o = count_r;
    assign frame_err_o  = frame_err_r;
    assign parity_err_o = parity_err_r;
    assign overflow_o   = overflow_r;
    assign busy_o       = busy_r;

endmodule
